gpio_bus_arbiter: RTL
=====================

# gpio_bus_arbiter

Two-requester arbiter that shares the single memory-mapped GPIO register port (addr/wdata/we/rdata) between the CPU load/store path (m0) and a second bus master such as a pattern sequencer or DMA (m1). Sits between the masters and the GPIO slave. Runs a three-state access FSM with round-robin priority, optional bounded bus locking and address-window checking. Each granted request becomes exactly one single-cycle GPIO access.

## Interface
- GPIO_ADDR, 32'h0000_0030: the only address decoded as the GPIO register.
- MAX_LOCK, 4: maximum consecutive grants to a locking master (≥1).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  level request, held until the matching done.
- m0_lock, m1_lock  in  1  request back-to-back ownership, sampled with req.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_gnt, m1_gnt  out  1  high during that master's ACCESS cycle.
- m0_done, m1_done  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  pulses with done when the address missed GPIO_ADDR.
- m0_rdata, m1_rdata  out  32  read result, valid from done, held until that master's next done.
- s_addr  out  32  to GPIO addr.
- s_wdata  out  32  to GPIO wdata.
- s_we  out  1  to GPIO we.
- s_rdata  in  32  from GPIO rdata (combinational from addr).

## Operation
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise pick a winner, latch its addr/wdata/we/lock and a hit flag (addr == GPIO_ADDR), then go to ACCESS.
- Winner selection, in priority order:
  1. A lock owner whose req is high and whose lock_cnt < MAX_LOCK.
  2. The single requester.
  3. When both request, the master that is not last_gnt.
- Record the winner in last_gnt. Reset value of last_gnt is m1, so m0 wins the first tie.
- Lock bookkeeping:
  - Winner sampled with lock=1 becomes or stays owner; lock_cnt increments, or restarts at 1 when the owner changes.
  - Winner with lock=0 clears ownership and lock_cnt.
  - When lock_cnt reaches MAX_LOCK the owner loses priority: the next IDLE does a plain round-robin, and ownership clears if the other master wins.
- ACCESS (exactly one cycle):
  - Winner's gnt = 1. s_addr and s_wdata are driven from the latched values.
  - s_we = latched we AND hit. A miss never writes the GPIO.
  - At the closing edge, winner's rdata is loaded with s_rdata on a hit, 32'h0 on a miss. For a write hit, the value loaded is the pre-write register value.
  - Go to RESP.
- RESP (one cycle):
  - Winner's done = 1; err = !hit.
  - s_we = 0. s_addr and s_wdata keep their last values.
  - Always go to IDLE.
- The non-winner's gnt, done, err and rdata are untouched throughout.

## Timing
- All outputs are registered.
- Reset values: state IDLE, all gnt/done/err 0, s_we 0, s_addr 0, s_wdata 0, m0_rdata/m1_rdata 0, lock_cnt 0, no owner.
- Latency: req sampled high at IDLE edge E → gnt during cycle E+1 → done during cycle E+2 → IDLE again at E+3. Throughput is 3 cycles per access.
- Request handshake:
  - A master with a further access keeps req high through its done cycle; the next IDLE samples it.
  - A master with no further access drops req at the edge ending its done cycle.
  - addr/wdata/we may change once gnt is seen.
- Requests arriving during ACCESS or RESP wait. Maximum wait for a non-locking master is 3 × (MAX_LOCK + 1) cycles.
- Reset asserted mid-transaction forces the reset values immediately, without waiting for a clock edge. s_we drops at once, so no GPIO write occurs unless its edge preceded reset. No done is issued for the aborted access.
- Simultaneous req in IDLE is resolved by the priority order only. There is no combinational path from req to any output.

## Test plan
- Single write: m0 writes 0xAA to 0x30 → m0_gnt in cycle 1 with s_we=1, s_addr=0x30, s_wdata=0xAA; m0_done in cycle 2 with m0_err=0; a subsequent m0 read returns m0_rdata=0xAA.
- Tie after reset: m0 and m1 request in the same cycle → m0 is served first, m1 immediately after (gnts 3 cycles apart). With both held high, grants alternate m0, m1, m0, m1.
- Lock bound: m1 holds req and lock high with MAX_LOCK=4 while m0 also requests → m1 is granted 4 consecutive times, then m0 is granted next.
- Address miss: m1 writes 0x55 to 0x34 → s_we stays 0, m1_done=1 with m1_err=1, m1_rdata=0, and a following read of 0x30 still shows the previous value.
- Reset mid-access: assert rst during ACCESS of a write of 0x0F → s_we, gnt and done all go to 0 without waiting for a clock edge, no done pulse appears, and the GPIO value is unchanged. After reset release, normal arbitration resumes with m0 preferred.
- Read-during-write ordering: m0 writes 0x12 while m1 has a read pending → m1's read, granted next, returns 0x12.

Source files
------------

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares the single GPIO register port between two bus
// masters. Each granted request becomes one single-cycle GPIO access,
// sequenced IDLE -> ACCESS -> RESP. Arbitration is round-robin, with an
// optional bounded lock that lets one master keep the port.
//
// Handshake: a master raises req, with addr/wdata/we/lock stable, and holds
// it until its done pulse. gnt marks the ACCESS cycle, after which the
// request fields may change. done marks the RESP cycle; err and rdata are
// valid from done. A master with no further work drops req at the edge that
// ends its done cycle.
module gpio_bus_arbiter #(
  parameter logic [31:0] GPIO_ADDR = 32'h0000_0030,
  parameter int          MAX_LOCK  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic        m0_we,
  input  logic        m1_we,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic        s_we,
  input  logic [31:0] s_rdata,
  output logic [1:0]  fsm_state
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e          state;
  state_e          state_next;
  logic            cur;          // master owning the current access (1 = m1)
  logic            hit;          // latched address match for the current access
  logic            last_gnt;     // most recent winner
  logic            owner_valid;  // a lock owner exists
  logic            owner;        // which master holds the lock
  logic [CW-1:0]   lock_cnt;     // consecutive grants to the lock owner

  logic            any_req;
  logic            owner_prio;
  logic            win;
  logic            win_lock;
  logic            win_we;
  logic [31:0]     win_addr;
  logic [31:0]     win_wdata;
  logic            win_hit;

  assign fsm_state = state;
  assign any_req   = m0_req | m1_req;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: an access always takes exactly ACCESS then RESP
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Winner selection: live lock owner first, then a lone requester, then round-robin
  always_comb begin
    owner_prio = owner_valid && (owner ? m1_req : m0_req) && (lock_cnt < CW'(MAX_LOCK));
    win        = 1'b0;
    if (owner_prio)            win = owner;
    else if (m0_req && !m1_req) win = 1'b0;
    else if (m1_req && !m0_req) win = 1'b1;
    else                        win = ~last_gnt;
    win_lock  = win ? m1_lock  : m0_lock;
    win_we    = win ? m1_we    : m0_we;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
    win_hit   = (win_addr == GPIO_ADDR);
  end

  // Registered datapath, handshake outputs and lock bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= 1'b0;
      hit         <= 1'b0;
      last_gnt    <= 1'b1;
      owner_valid <= 1'b0;
      owner       <= 1'b0;
      lock_cnt    <= '0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_done     <= 1'b0;
      m1_done     <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_we        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cur      <= win;
            hit      <= win_hit;
            last_gnt <= win;
            s_addr   <= win_addr;
            s_wdata  <= win_wdata;
            // A miss never writes the GPIO register
            s_we     <= win_we & win_hit;
            m0_gnt   <= ~win;
            m1_gnt   <= win;
            if (win_lock) begin
              if (owner_valid && owner == win) begin
                // Saturate: once the bound is reached the owner only competes round-robin
                if (lock_cnt < CW'(MAX_LOCK)) lock_cnt <= lock_cnt + CW'(1);
              end else begin
                owner_valid <= 1'b1;
                owner       <= win;
                lock_cnt    <= CW'(1);
              end
            end else begin
              owner_valid <= 1'b0;
              lock_cnt    <= '0;
            end
          end
        end
        ACCESS: begin
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          s_we   <= 1'b0;
          // s_rdata still shows the pre-write value at this edge
          if (cur) begin
            m1_done  <= 1'b1;
            m1_err   <= ~hit;
            m1_rdata <= hit ? s_rdata : 32'h0;
          end else begin
            m0_done  <= 1'b1;
            m0_err   <= ~hit;
            m0_rdata <= hit ? s_rdata : 32'h0;
          end
        end
        RESP: begin
          m0_done <= 1'b0;
          m1_done <= 1'b0;
          m0_err  <= 1'b0;
          m1_err  <= 1'b0;
        end
        default: begin
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          s_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule
